stf_detector: RTL and testbench

Receive-side detector for the 802.11 legacy short training field (L-STF). The L-STF is the periodic 16-sample preamble that the TX side plays out from its table. The block sits after the RX sample front end. It runs a delay-16 autocorrelation against a windowed power estimate on the incoming I/Q stream. It pulses `short_preamble_detected` once a correlation plateau has lasted long enough, so downstream long-preamble sync and CFO estimation can start.

---
 rtl/stf_detector.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_stf_detector.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stf_detector.sv
// L-STF detector: delay-16 autocorrelation vs windowed power, plateau FSM.
// Ports: clk, rstn, enable, sample_in/_strobe, power_thres, min_plateau ->
//   short_preamble_detected, detected_hold, state
//   (+ corr_i/corr_q with `define STF_DETECTOR_CORR_OUT_EN).
module stf_detector #(
   parameter int WIN_LEN = 16,
   parameter int ACC_W   = 40
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic [31:0] sample_in,
   input  logic        sample_in_strobe,
   input  logic [15:0] power_thres,
   input  logic [15:0] min_plateau,
`ifdef STF_DETECTOR_CORR_OUT_EN
   output logic [31:0] corr_i,
   output logic [31:0] corr_q,
`endif
   output logic        short_preamble_detected,
   output logic        detected_hold,
   output logic [1:0]  state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_SEARCH = 2'd2;
   localparam logic [1:0] S_DET    = 2'd3;

   localparam int FILL_N = 2 * WIN_LEN;
   localparam int FILL_W = $clog2(FILL_N) + 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_N - 1);

   // stage 1: current and 16-strobes-old sample
   logic [31:0] dly_q [WIN_LEN];
   logic [31:0] dly_d [WIN_LEN];
   logic        v1_q, v1_d;
   logic [31:0] cur_q, cur_d;
   logic [31:0] old_q, old_d;

   // stage 2: product and power, plus their 16-deep history
   logic        v2_q, v2_d;
   logic [32:0] pre_q, pre_d;
   logic [32:0] pim_q, pim_d;
   logic [32:0] pw_q, pw_d;
   logic [32:0] hre_q [WIN_LEN];
   logic [32:0] hre_d [WIN_LEN];
   logic [32:0] him_q [WIN_LEN];
   logic [32:0] him_d [WIN_LEN];
   logic [32:0] hpw_q [WIN_LEN];
   logic [32:0] hpw_d [WIN_LEN];

   // stage 3: windowed sums
   logic             v3_q, v3_d;
   logic [ACC_W-1:0] c_re_q, c_re_d;
   logic [ACC_W-1:0] c_im_q, c_im_d;
   logic [ACC_W-1:0] p_q, p_d;

   // stage 4: registered hit
   logic v4_q, v4_d;
   logic hit_q, hit_d;

   // control
   logic [1:0]        state_q, state_d;
   logic [15:0]       plat_q, plat_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              pulse_q, pulse_d;
   logic              hold_q, hold_d;

`ifdef STF_DETECTOR_CORR_OUT_EN
   logic [31:0] c4_re_q, c4_re_d;
   logic [31:0] c4_im_q, c4_im_d;
   logic [31:0] corr_i_q, corr_i_d;
   logic [31:0] corr_q_q, corr_q_d;
`endif

   logic signed [32:0] ci_x, cq_x, oi_x, oq_x;
   logic [ACC_W-1:0]   are, aim;
   logic [ACC_W:0]     mag, thr, p_x;
   logic               hit_c;

   always_comb begin
      are   = c_re_q[ACC_W-1] ? (~c_re_q + ACC_W'(1)) : c_re_q;
      aim   = c_im_q[ACC_W-1] ? (~c_im_q + ACC_W'(1)) : c_im_q;
      mag   = {1'b0, are} + {1'b0, aim};
      p_x   = {1'b0, p_q};
      // 0.75 * P
      thr   = (p_x >> 1) + (p_x >> 2);
      hit_c = (mag > thr) && (p_q[ACC_W-1 -: 16] >= power_thres);
   end

   always_comb begin
      dly_d = dly_q;
      v1_d  = sample_in_strobe;
      cur_d = cur_q;
      old_d = old_q;
      if (sample_in_strobe) begin
         cur_d    = sample_in;
         old_d    = dly_q[WIN_LEN-1];
         dly_d[0] = sample_in;
         for (int i = 1; i < WIN_LEN; i++) dly_d[i] = dly_q[i-1];
      end

      ci_x  = {{17{cur_q[31]}}, cur_q[31:16]};
      cq_x  = {{17{cur_q[15]}}, cur_q[15:0]};
      oi_x  = {{17{old_q[31]}}, old_q[31:16]};
      oq_x  = {{17{old_q[15]}}, old_q[15:0]};
      v2_d  = v1_q;
      pre_d = pre_q;
      pim_d = pim_q;
      pw_d  = pw_q;
      if (v1_q) begin
         // s[n] * conj(s[n-16])
         pre_d = ci_x * oi_x + cq_x * oq_x;
         pim_d = cq_x * oi_x - ci_x * oq_x;
         pw_d  = ci_x * ci_x + cq_x * cq_x;
      end

      v3_d   = v2_q;
      hre_d  = hre_q;
      him_d  = him_q;
      hpw_d  = hpw_q;
      c_re_d = c_re_q;
      c_im_d = c_im_q;
      p_d    = p_q;
      if (v2_q) begin
         c_re_d = c_re_q + {{(ACC_W-33){pre_q[32]}}, pre_q}
                         - {{(ACC_W-33){hre_q[WIN_LEN-1][32]}}, hre_q[WIN_LEN-1]};
         c_im_d = c_im_q + {{(ACC_W-33){pim_q[32]}}, pim_q}
                         - {{(ACC_W-33){him_q[WIN_LEN-1][32]}}, him_q[WIN_LEN-1]};
         p_d    = p_q + {{(ACC_W-33){1'b0}}, pw_q}
                      - {{(ACC_W-33){1'b0}}, hpw_q[WIN_LEN-1]};
         hre_d[0] = pre_q;
         him_d[0] = pim_q;
         hpw_d[0] = pw_q;
         for (int i = 1; i < WIN_LEN; i++) begin
            hre_d[i] = hre_q[i-1];
            him_d[i] = him_q[i-1];
            hpw_d[i] = hpw_q[i-1];
         end
      end

      v4_d  = v3_q;
      hit_d = hit_q;
      if (v3_q) hit_d = hit_c;
`ifdef STF_DETECTOR_CORR_OUT_EN
      c4_re_d = c4_re_q;
      c4_im_d = c4_im_q;
      if (v3_q) begin
         c4_re_d = c_re_q[ACC_W-1 -: 32];
         c4_im_d = c_im_q[ACC_W-1 -: 32];
      end
`endif

      if (!enable) begin
         dly_d  = '{default: '0};
         v1_d   = 1'b0;
         cur_d  = '0;
         old_d  = '0;
         v2_d   = 1'b0;
         pre_d  = '0;
         pim_d  = '0;
         pw_d   = '0;
         hre_d  = '{default: '0};
         him_d  = '{default: '0};
         hpw_d  = '{default: '0};
         v3_d   = 1'b0;
         c_re_d = '0;
         c_im_d = '0;
         p_d    = '0;
         v4_d   = 1'b0;
         hit_d  = 1'b0;
`ifdef STF_DETECTOR_CORR_OUT_EN
         c4_re_d = '0;
         c4_im_d = '0;
`endif
      end
   end

   logic [15:0] plat_inc, mp_eff;

   always_comb begin
      plat_inc = (plat_q == 16'hFFFF) ? plat_q : plat_q + 16'd1;
      mp_eff   = (min_plateau == 16'd0) ? 16'd1 : min_plateau;
      state_d  = state_q;
      plat_d   = plat_q;
      fill_d   = fill_q;
      pulse_d  = 1'b0;
      hold_d   = hold_q;
`ifdef STF_DETECTOR_CORR_OUT_EN
      corr_i_d = corr_i_q;
      corr_q_d = corr_q_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_FILL;
         S_FILL: begin
            if (v4_q) begin
               if (fill_q == FILL_LAST) state_d = S_SEARCH;
               else fill_d = fill_q + FILL_W'(1);
            end
         end
         S_SEARCH: begin
            if (v4_q) begin
               if (hit_q) begin
                  plat_d = plat_inc;
                  if (plat_inc >= mp_eff) begin
                     pulse_d = 1'b1;
                     hold_d  = 1'b1;
                     state_d = S_DET;
`ifdef STF_DETECTOR_CORR_OUT_EN
                     corr_i_d = c4_re_q;
                     corr_q_d = c4_im_q;
`endif
                  end
               end else begin
                  plat_d = '0;
               end
            end
         end
         S_DET: state_d = S_DET;
         default: state_d = S_IDLE;
      endcase
      if (!enable) begin
         state_d = S_IDLE;
         plat_d  = '0;
         fill_d  = '0;
         pulse_d = 1'b0;
         hold_d  = 1'b0;
`ifdef STF_DETECTOR_CORR_OUT_EN
         corr_i_d = '0;
         corr_q_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dly_q   <= '{default: '0};
         v1_q    <= 1'b0;
         cur_q   <= '0;
         old_q   <= '0;
         v2_q    <= 1'b0;
         pre_q   <= '0;
         pim_q   <= '0;
         pw_q    <= '0;
         hre_q   <= '{default: '0};
         him_q   <= '{default: '0};
         hpw_q   <= '{default: '0};
         v3_q    <= 1'b0;
         c_re_q  <= '0;
         c_im_q  <= '0;
         p_q     <= '0;
         v4_q    <= 1'b0;
         hit_q   <= 1'b0;
         state_q <= S_IDLE;
         plat_q  <= '0;
         fill_q  <= '0;
         pulse_q <= 1'b0;
         hold_q  <= 1'b0;
`ifdef STF_DETECTOR_CORR_OUT_EN
         c4_re_q  <= '0;
         c4_im_q  <= '0;
         corr_i_q <= '0;
         corr_q_q <= '0;
`endif
      end else begin
         dly_q   <= dly_d;
         v1_q    <= v1_d;
         cur_q   <= cur_d;
         old_q   <= old_d;
         v2_q    <= v2_d;
         pre_q   <= pre_d;
         pim_q   <= pim_d;
         pw_q    <= pw_d;
         hre_q   <= hre_d;
         him_q   <= him_d;
         hpw_q   <= hpw_d;
         v3_q    <= v3_d;
         c_re_q  <= c_re_d;
         c_im_q  <= c_im_d;
         p_q     <= p_d;
         v4_q    <= v4_d;
         hit_q   <= hit_d;
         state_q <= state_d;
         plat_q  <= plat_d;
         fill_q  <= fill_d;
         pulse_q <= pulse_d;
         hold_q  <= hold_d;
`ifdef STF_DETECTOR_CORR_OUT_EN
         c4_re_q  <= c4_re_d;
         c4_im_q  <= c4_im_d;
         corr_i_q <= corr_i_d;
         corr_q_q <= corr_q_d;
`endif
      end
   end

   assign short_preamble_detected = pulse_q;
   assign detected_hold           = hold_q;
   assign state                   = state_q;
`ifdef STF_DETECTOR_CORR_OUT_EN
   assign corr_i = corr_i_q;
   assign corr_q = corr_q_q;
`endif

endmodule

// File: tb/tb_stf_detector.sv
// Randomized bench for stf_detector with a windowed-sum reference model.
// Optional corr_i/corr_q checks when STF_DETECTOR_CORR_OUT_EN is defined.
module tb_stf_detector;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] sample_in = '0;
   logic        sample_in_strobe = 1'b0;
   logic [15:0] power_thres = 16'd1;
   logic [15:0] min_plateau = 16'd1;
   logic        spd;
   logic        hold;
   logic [1:0]  state;
`ifdef STF_DETECTOR_CORR_OUT_EN
   logic [31:0] corr_i;
   logic [31:0] corr_q;
`endif

   stf_detector dut (
      .clk                     (clk),
      .rstn                    (rstn),
      .enable                  (enable),
      .sample_in               (sample_in),
      .sample_in_strobe        (sample_in_strobe),
      .power_thres             (power_thres),
      .min_plateau             (min_plateau),
`ifdef STF_DETECTOR_CORR_OUT_EN
      .corr_i                  (corr_i),
      .corr_q                  (corr_q),
`endif
      .short_preamble_detected (spd),
      .detected_hold           (hold),
      .state                   (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pulses = 0;
   int last_pulse = -1;
   always @(negedge clk) begin
      if (spd === 1'b1) begin
         pulses++;
         last_pulse = cyc;
      end
   end

   int checks = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   shortint lstf_i [16] = '{4600, -13200, -1300, 14300, 9200, 14300,
                            -1300, -13200, 4600, 200, -7900, -1300,
                            0, -1300, -7900, 200};
   shortint lstf_q [16] = '{4600, 200, -7900, -1300, 0, -1300,
                            -7900, 200, 4600, -13200, -1300, 14300,
                            9200, 14300, -1300, -13200};

   function automatic logic [31:0] lstf(input int n);
      int k;
      k = n % 16;
      return {lstf_i[k], lstf_q[k]};
   endfunction

   function automatic longint re_of(input logic [31:0] s);
      return longint'($signed(s[31:16]));
   endfunction

   function automatic longint im_of(input logic [31:0] s);
      return longint'($signed(s[15:0]));
   endfunction

   // reference model: samples since enable rose, windows recomputed
   logic [31:0] hist [$];
   int     m_plat = 0;
   bit     m_det = 1'b0;
   int     m_pulses = 0;
   int     m_exp_cyc = -1;
   longint m_cre = 0;
   longint m_cim = 0;

   task automatic model_clear();
      hist.delete();
      m_plat = 0;
      m_det = 1'b0;
      if (m_exp_cyc > cyc) begin
         m_pulses--;
         m_exp_cyc = -1;
      end
   endtask

   task automatic model_strobe(input logic [31:0] s);
      longint cre, cim, p, a, b, c, d, mag;
      int k, mp;
      bit hit;
      hist.push_back(s);
      k = hist.size() - 1;
      if (k < 32 || m_det) return;
      cre = 0;
      cim = 0;
      p = 0;
      for (int j = k - 15; j <= k; j++) begin
         a = re_of(hist[j]);
         b = im_of(hist[j]);
         c = re_of(hist[j-16]);
         d = im_of(hist[j-16]);
         cre += a * c + b * d;
         cim += b * c - a * d;
         p += a * a + b * b;
      end
      mag = (cre < 0 ? -cre : cre) + (cim < 0 ? -cim : cim);
      hit = (mag > (p >> 1) + (p >> 2)) &&
            ((p >> 24) >= longint'(power_thres));
      mp = (min_plateau == 16'd0) ? 1 : int'(min_plateau);
      if (!hit) begin
         m_plat = 0;
      end else begin
         if (m_plat < 65535) m_plat++;
         if (m_plat >= mp) begin
            m_det = 1'b1;
            m_pulses++;
            m_exp_cyc = cyc + 5;
            m_cre = cre;
            m_cim = cim;
         end
      end
   endtask

   function automatic logic [1:0] exp_state();
      if (!enable) return 2'd0;
      if (m_det) return 2'd3;
      if (hist.size() >= 32) return 2'd2;
      return 2'd1;
   endfunction

   task automatic step(input bit en, input bit stb, input logic [31:0] s);
      @(posedge clk);
      #1;
      if (!en) model_clear();
      enable = en;
      sample_in_strobe = stb;
      sample_in = s;
      if (en && stb) model_strobe(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(enable, 1'b0, 32'd0);
   endtask

   task automatic off(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
   endtask

   task automatic check_end(input string tag, input int p0, input int m0);
      chk({tag, "_pulses"}, pulses - p0, m_pulses - m0);
      chk({tag, "_state"}, state, exp_state());
      chk({tag, "_hold"}, hold, m_det);
      if (m_pulses - m0 == 1) chk({tag, "_when"}, last_pulse, m_exp_cyc);
   endtask

   int p0, m0, t0;
   logic [31:0] s;
   int ni, nq, drop_at, gap;
   real ang;

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #2;
      chk("rst_state", state, 2'd0);
      chk("rst_pulse", spd, 1'b0);
      chk("rst_hold", hold, 1'b0);
      @(posedge clk);
      #1 rstn = 1'b1;
      off(3);
      chk("idle_state", state, 2'd0);

      // L-STF x10, one strobe per cycle
      power_thres = 16'd1;
      min_plateau = 16'd100;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 160; n++) begin
         step(1'b1, 1'b1, lstf(n));
         if (n == 0) t0 = cyc;
      end
      idle(8);
      check_end("lstf", p0, m0);
      chk("lstf_cnt", pulses - p0, 1);
      chk("lstf_t", last_pulse, t0 + 131 + 5);
      chk("lstf_st3", state, 2'd3);
      off(2);
      chk("lstf_off_st", state, 2'd0);
      chk("lstf_off_hold", hold, 1'b0);

      // all-zero input
      min_plateau = 16'd4;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 500; n++) step(1'b1, 1'b1, 32'd0);
      idle(8);
      check_end("zero", p0, m0);
      chk("zero_none", pulses - p0, 0);
      chk("zero_st2", state, 2'd2);
      off(2);

      // full-scale noise
      min_plateau = 16'd48;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 1000; n++) step(1'b1, 1'b1, $urandom());
      idle(8);
      check_end("noise", p0, m0);
      chk("noise_none", pulses - p0, 0);
      off(2);

      // enable dropped at strobe 80, then refill
      min_plateau = 16'd100;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 80; n++) step(1'b1, 1'b1, lstf(n));
      off(3);
      chk("drop_none", pulses - p0, 0);
      chk("drop_st", state, 2'd0);
      for (int n = 0; n < 160; n++) begin
         step(1'b1, 1'b1, lstf(n));
         if (n == 0) t0 = cyc;
      end
      idle(8);
      check_end("redo", p0, m0);
      chk("redo_t", last_pulse, t0 + 131 + 5);
      off(2);

      // strobe every third cycle
      min_plateau = 16'd50;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 100; n++) begin
         step(1'b1, 1'b1, lstf(n));
         if (n == 81) t0 = cyc;
         step(1'b1, 1'b0, 32'd0);
         step(1'b1, 1'b0, 32'd0);
      end
      idle(8);
      check_end("gap3", p0, m0);
      chk("gap3_t", last_pulse, t0 + 5);
      off(2);

      // min_plateau 0 acts as 1
      min_plateau = 16'd0;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 40; n++) begin
         step(1'b1, 1'b1, lstf(n));
         if (n == 32) t0 = cyc;
      end
      idle(8);
      check_end("mp0", p0, m0);
      chk("mp0_t", last_pulse, t0 + 5);

      // asynchronous reset while detected
      chk("pre_rst_hold", hold, 1'b1);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("arst_hold", hold, 1'b0);
      chk("arst_state", state, 2'd0);
      chk("arst_pulse", spd, 1'b0);
      enable = 1'b0;
      model_clear();
      @(posedge clk);
      #1 rstn = 1'b1;
      off(2);

      // randomized mixes of noise and noisy L-STF
      for (int it = 0; it < 4; it++) begin
         min_plateau = 16'($urandom_range(1, 24));
         power_thres = 16'($urandom_range(0, 200));
         drop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 100)) : -1;
         p0 = pulses;
         m0 = m_pulses;
         for (int n = 0; n < 160; n++) begin
            if (n == drop_at) step(1'b0, 1'b0, 32'd0);
            if (n < 40) begin
               s = $urandom();
            end else begin
               ni = int'(lstf_i[n % 16]) + int'($urandom_range(0, 2000)) - 1000;
               nq = int'(lstf_q[n % 16]) + int'($urandom_range(0, 2000)) - 1000;
               s = {ni[15:0], nq[15:0]};
            end
            step(1'b1, 1'b1, s);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 32'd0);
         end
         idle(8);
         check_end("rand", p0, m0);
         off(2);
      end

`ifdef STF_DETECTOR_CORR_OUT_EN
      // rotated L-STF, +0.01 rad/sample
      power_thres = 16'd1;
      min_plateau = 16'd20;
      p0 = pulses;
      m0 = m_pulses;
      for (int n = 0; n < 80; n++) begin
         ang = 0.01 * n;
         ni = $rtoi(lstf_i[n % 16] * $cos(ang) - lstf_q[n % 16] * $sin(ang));
         nq = $rtoi(lstf_i[n % 16] * $sin(ang) + lstf_q[n % 16] * $cos(ang));
         step(1'b1, 1'b1, {ni[15:0], nq[15:0]});
      end
      idle(8);
      check_end("rot", p0, m0);
      chk("rot_ci", longint'($signed(corr_i)), m_cre >>> 8);
      chk("rot_cq", longint'($signed(corr_q)), m_cim >>> 8);
      chk("rot_ci_pos", $signed(corr_i) > 0, 1'b1);
      chk("rot_cq_pos", $signed(corr_q) > 0, 1'b1);
      idle(10);
      chk("rot_ci_held", longint'($signed(corr_i)), m_cre >>> 8);
      off(2);
      chk("rot_ci_clr", corr_i, 32'd0);
      chk("rot_cq_clr", corr_q, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
